// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse timing blocks (one-shot, stretcher, ...).
package pulse_pkg;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_HOLDOFF = 2'd2
  } state_e;
endpackage

// File: rtl/pulse_stretcher_if.sv
// Trigger/level bundle between an event producer and the pulse stretcher.
interface pulse_stretcher_if #(parameter int CNT_W = pulse_pkg::CNT_W_DEF);
  logic             trig;
  logic [CNT_W-1:0] len;
  logic             retrig_en;
  logic             level;
  logic             busy;
  logic             overrun;

  modport master (output trig, len, retrig_en, input level, busy, overrun);
  modport slave  (input trig, len, retrig_en, output level, busy, overrun);
endinterface

// File: rtl/pulse_stretcher_load_down_counter.sv
// Loadable down counter with zero flag; shared by length and hold-off phases.
module load_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)     cnt_d = load_val_i;
    else if (dec_i) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/pulse_stretcher.sv
// Stretches a one-cycle trigger into a level of len cycles, with optional
// retrigger, a post-pulse hold-off window and an overrun flag for refused events.
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int HOLDOFF = 4
) (
  input logic         clk,
  input logic         rst,
  pulse_stretcher_if.slave ps
);
  localparam bit               HAS_HO  = (HOLDOFF > 0);
  localparam logic [CNT_W-1:0] HO_LOAD = HAS_HO ? CNT_W'(HOLDOFF - 1) : '0;

  if (HOLDOFF < 0 || HOLDOFF >= (1 << CNT_W)) begin : g_bad_holdoff
    $error("pulse_stretcher: HOLDOFF must fit in CNT_W bits");
  end

  state_e           state_q;
  logic             level_q, busy_q, overrun_q;
  logic             zero;
  logic             len_nz, accept, retrig, refuse, act_end;
  logic             ld, dec;
  logic [CNT_W-1:0] ld_val;

  always_comb begin
    len_nz  = (ps.len != '0);
    accept  = (state_q == S_IDLE)   && ps.trig && len_nz;
    retrig  = (state_q == S_ACTIVE) && ps.trig && ps.retrig_en && len_nz;
    // A zero-length retrigger is ignored silently, not counted as an overrun.
    refuse  = ps.trig && (((state_q == S_ACTIVE) && !ps.retrig_en) ||
                          (state_q == S_HOLDOFF));
    act_end = (state_q == S_ACTIVE) && zero && !retrig;
    ld      = accept || retrig || (act_end && HAS_HO);
    ld_val  = (accept || retrig) ? ps.len - CNT_W'(1) : HO_LOAD;
    dec     = !ld && (state_q != S_IDLE) && !zero;
  end

  load_down_counter #(.W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ld),
    .load_val_i (ld_val),
    .dec_i      (dec),
    .zero_o     (zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      level_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= refuse;
      case (state_q)
        S_IDLE: if (accept) begin
          state_q <= S_ACTIVE;
          level_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        S_ACTIVE: if (act_end) begin
          level_q <= 1'b0;
          if (HAS_HO) begin
            state_q <= S_HOLDOFF;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_HOLDOFF: if (zero) begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          level_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ps.level   = level_q;
  assign ps.busy    = busy_q;
  assign ps.overrun = overrun_q;
endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench: HOLDOFF=4 and HOLDOFF=0 stretchers driven with identical inputs.
module tb_pulse_stretcher;
  logic clk = 1'b0;
  logic rst = 1'b1;

  pulse_stretcher_if #(.CNT_W(8)) ps4 ();
  pulse_stretcher_if #(.CNT_W(8)) ps0 ();

  pulse_stretcher #(.CNT_W(8), .HOLDOFF(4)) dut  (.clk(clk), .rst(rst), .ps(ps4));
  pulse_stretcher #(.CNT_W(8), .HOLDOFF(0)) dut0 (.clk(clk), .rst(rst), .ps(ps0));

  always #5 clk = ~clk;

  typedef struct {
    string    nm;
    bit       first;
    bit       d0;
    int       cyc;
    bit       trig;
    bit [7:0] len;
    bit       rt;
    bit [2:0] exp;
  } vec_t;

  vec_t vq[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic bit in(int c, int a, int b);
    return (c >= a) && (c <= b);
  endfunction

  task automatic push(string nm, int c, bit d0, bit tg, int ln, bit rt, bit l, bit b, bit o);
    vec_t v;
    v.nm = nm; v.first = (c == 0); v.d0 = d0; v.cyc = c;
    v.trig = tg; v.len = 8'(ln); v.rt = rt; v.exp = {l, b, o};
    vq.push_back(v);
  endtask

  task automatic drive(bit tg, bit [7:0] ln, bit rt);
    ps4.trig = tg; ps4.len = ln; ps4.retrig_en = rt;
    ps0.trig = tg; ps0.len = ln; ps0.retrig_en = rt;
  endtask

  task automatic check(string nm, int c, bit [2:0] got, bit [2:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s cyc %0d: level/busy/overrun got %b want %b", nm, c, got, exp);
    end
  endtask

  function automatic bit [2:0] outs(bit d0);
    return d0 ? {ps0.level, ps0.busy, ps0.overrun} : {ps4.level, ps4.busy, ps4.overrun};
  endfunction

  task automatic do_reset();
    drive(1'b0, 8'd0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Row c: inputs applied during cycle c, expected outputs visible during cycle c.
    for (int c = 0; c < 23; c++)
      push("basic", c, 0, c == 10, 5, 0, in(c, 11, 15), in(c, 11, 19), 0);
    for (int c = 0; c < 26; c++)
      push("retrig", c, 0, c == 10 || c == 13, 5, 1, in(c, 11, 18), in(c, 11, 22), 0);
    for (int c = 0; c < 33; c++)
      push("noretrig", c, 0, c == 10 || c == 13 || c == 17 || c == 21, 5, 0,
           in(c, 11, 15) || in(c, 22, 26), in(c, 11, 19) || in(c, 22, 30), c == 14 || c == 18);
    for (int c = 0; c < 33; c++)
      push("ho_exit", c, 0, c == 10 || c == 19 || c == 21, 5, 0,
           in(c, 11, 15) || in(c, 22, 26), in(c, 11, 19) || in(c, 22, 30), c == 20);
    for (int c = 0; c < 15; c++)
      push("len0", c, 0, c == 10, 0, 0, 0, 0, 0);
    for (int c = 0; c < 22; c++)
      push("retrig_len0", c, 0, c == 10 || c == 12, (c == 12) ? 0 : 5, 1,
           in(c, 11, 15), in(c, 11, 19), 0);
    for (int c = 0; c < 27; c++)
      push("retrig_last", c, 0, c == 10 || c == 15, 5, 1, in(c, 11, 20), in(c, 11, 24), 0);
    for (int c = 0; c < 264; c++)
      push("len255", c, 0, c == 2, 255, 0, in(c, 3, 257), in(c, 3, 261), 0);
    for (int c = 0; c < 13; c++)
      push("ho0", c, 1, c == 2 || c == 6, 3, 0, in(c, 3, 5) || in(c, 7, 9),
           in(c, 3, 5) || in(c, 7, 9), 0);

    // Reset held with trig high: both instances stay quiet.
    drive(1'b1, 8'd5, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold", i, outs(0), 3'b000);
      check("rst_hold0", i, outs(1), 3'b000);
    end
    rst = 1'b0;
    drive(1'b0, 8'd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_release", i, outs(0), 3'b000);
    end

    foreach (vq[i]) begin
      if (vq[i].first) do_reset();
      check(vq[i].nm, vq[i].cyc, outs(vq[i].d0), vq[i].exp);
      drive(vq[i].trig, vq[i].len, vq[i].rt);
      @(negedge clk);
    end

    // Async reset in the middle of a len=5 pulse.
    do_reset();
    for (int c = 0; c < 13; c++) begin
      drive(c == 10, 8'd5, 1'b0);
      @(negedge clk);
    end
    check("mid_pre", 13, outs(0), 3'b110);
    #2 rst = 1'b1;
    #1 check("mid_async", 13, outs(0), 3'b000);
    @(negedge clk);
    rst = 1'b0;
    check("mid_held", 14, outs(0), 3'b000);
    drive(1'b0, 8'd2, 1'b0);
    @(negedge clk);
    check("post_idle", 0, outs(0), 3'b000);
    drive(1'b1, 8'd2, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'd2, 1'b0);
    for (int c = 1; c < 9; c++) begin
      check("post_len2", c, outs(0), {in(c, 1, 2), in(c, 1, 6), 1'b0});
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
Converts a single-cycle event pulse (e.g. from the button one-shot) into a clean level of programmable length. Typical loads are LEDs, buzzer enables and downstream blocks that need a multi-cycle enable.
Sits on the consumer side of the one-shot interface: one-shot turns a level into a pulse; this block turns a pulse back into a timed level.
Includes a retrigger option, a post-pulse hold-off window and an overrun flag for dropped events.

Parameters:
CNT_W, 8, width of the length counter and the len input.
HOLDOFF, 4, cycles after the level falls during which new triggers are refused (0 = no hold-off).

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  reset, asynchronous, active-high
trig  input  1  event input; every cycle sampled high is one trigger event
len  input  CNT_W  stretch length in cycles; sampled only when a trigger is accepted
retrig_en  input  1  1 = a trigger during ACTIVE restarts the length count
level  output  1  stretched output, registered
busy  output  1  high in ACTIVE or HOLDOFF, registered
overrun  output  1  one-cycle pulse when a trigger is refused, registered

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: state=IDLE, counter=0, level=0, busy=0, overrun=0. Reset mid-pulse kills level in the same instant; no residual pulse after release.
- All outputs are registered, Moore style. level equals (state==ACTIVE).
- State machine (IDLE, ACTIVE, HOLDOFF):
  - IDLE, trig=1, len!=0 -> ACTIVE; cnt<=len-1. level rises the cycle after trig (latency 1).
  - IDLE, trig=1, len==0 -> stay IDLE; event ignored, no overrun.
  - ACTIVE, cnt!=0 -> cnt decrements by 1.
  - ACTIVE, cnt==0 and no accepted retrigger -> HOLDOFF (cnt<=HOLDOFF-1) if HOLDOFF>0, else IDLE.
  - Net result: level is high for exactly len consecutive cycles per accepted trigger.
  - ACTIVE, trig=1, retrig_en=1, len!=0 -> cnt<=len-1. level stays high with no glitch, so it ends len cycles after the retrigger. This includes a trig on the final ACTIVE cycle, which extends the pulse.
  - ACTIVE, trig=1, retrig_en=1, len==0 -> event ignored; count continues.
  - ACTIVE, trig=1, retrig_en=0 -> event dropped; overrun=1 the next cycle only.
  - HOLDOFF, cnt!=0 -> cnt decrements. cnt==0 -> IDLE.
  - HOLDOFF, trig=1 -> event dropped; overrun pulse.
  - A trig in the cycle that HOLDOFF exits is also dropped. A trigger is accepted only when sampled while in IDLE.
- Arithmetic and width rules:
  - Counter is CNT_W bits; len-1 is computed only when len!=0, so there is no wrap.
  - Maximum stretch is 2^CNT_W-1 cycles.
  - HOLDOFF must be < 2^CNT_W (elaboration-time assertion).
- Signal relationships:
  - busy=1 exactly while the state is ACTIVE or HOLDOFF.
  - overrun never coincides with an accepted trigger.
  - Consecutive refused triggers give consecutive overrun cycles.
- Inputs: trig is assumed synchronous to clk. Synchronising it is the one-shot's job upstream.

Decomposition:
- Shared package pulse_pkg holds:
  - the state enum (IDLE, ACTIVE, HOLDOFF), 2-bit logic;
  - a default CNT_W localparam, shared with the one-shot and other timing blocks.
- One natural sub-module: load_down_counter. It has a synchronous load with load value, a decrement enable, a zero flag, and async active-high reset. It is reused for both the length phase and the hold-off phase.
- The FSM, overrun register and output registers stay in pulse_stretcher.

Test Plan:
1. Reset check: hold rst=1 for 3 cycles with trig=1 -> level=busy=overrun=0 throughout. Release, keep trig=0 -> outputs stay 0.
2. Basic stretch: len=5, HOLDOFF=4, one trig pulse at cycle 10 -> level high cycles 11..15, busy high cycles 11..19, IDLE at cycle 20, overrun never asserted.
3. Retrigger: retrig_en=1, len=5, trig at cycles 10 and 13 -> level continuously high cycles 11..18 with no gap; no overrun.
4. No-retrigger and hold-off: retrig_en=0, len=5, trig at cycles 10, 13 and 17 -> level high cycles 11..15; overrun pulses at cycles 14 and 18; trig at 21 is accepted, giving level high 22..26.
5. Edge cases:
   - len=0 with trig -> no level, no busy, no overrun.
   - len=255 (CNT_W=8) -> level high exactly 255 cycles.
   - HOLDOFF=0 build, trig on the cycle after level falls -> accepted immediately.
6. Async reset mid-pulse: assert rst at cycle 13 of a len=5 pulse -> level drops without waiting for clk. After release, a new trig with len=2 gives level high exactly 2 cycles.
